// File: rtl/zero_count_pkg.sv
// Shared types for the zero-count unit.
//   zc_state_t : controller states (idle, binary search in progress, result held)
//   zc_mode_t  : operation select (count leading zeros / count trailing zeros)
package zero_count_pkg;

  typedef enum logic [1:0] {ZC_IDLE, ZC_SEARCH, ZC_DONE} zc_state_t;
  typedef enum logic {ZC_CLZ, ZC_CTZ} zc_mode_t;

endpackage

// File: rtl/bit_reverse.sv
// Purely combinational bit reversal. The trailing-zero path reuses the
// leading-zero search by reversing the operand on capture.
//   i_data : operand
//   o_data : operand with bit i moved to bit WIDTH-1-i
module bit_reverse #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_rev
    assign o_data[g] = i_data[WIDTH-1-g];
  end

endmodule

// File: rtl/zero_count_unit.sv
// Multi-cycle leading/trailing zero counter with valid/ready handshakes.
// A binary search halves the window once per clock, so the result of a
// non-zero operand is ready LOG2W clocks after the accept edge; an all-zero
// operand skips the search and is ready right after the accept edge.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   flush                 synchronous abort of any in-flight or unread result
//   in_valid/in_ready     request handshake (in_ready combinationally follows
//                         out_ready while a result is held, for back-to-back use)
//   in_data/in_mode/in_tag  operand, CLZ(0)/CTZ(1), sideband tag
//   out_valid/out_ready   result handshake
//   out_count/out_zero/out_tag  zero count 0..WIDTH, all-zero flag, echoed tag
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ZC_IDLE   | no operation; ready to accept
// ZC_SEARCH | halving the search window, one step per clock
// ZC_DONE   | result presented, held until out_ready
module zero_count_unit
  import zero_count_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH):0]   out_count,
  output logic                     out_zero,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int CW    = LOG2W + 1;
  localparam int SW    = LOG2W;

  zc_state_t        r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sr, w_sr_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic [SW-1:0]    r_step, w_step_nxt;
  logic [TAG_W-1:0] r_tag, w_tag_nxt;
  logic             r_zero, w_zero_nxt;

  logic [WIDTH-1:0] w_rev;
  logic [WIDTH-1:0] w_capture;
  logic [CW-1:0]    w_half;
  logic [WIDTH-1:0] w_mask;
  logic             w_upper_zero;
  logic             w_accept;

  bit_reverse #(.WIDTH(WIDTH)) u_bit_reverse (
    .i_data (in_data),
    .o_data (w_rev)
  );

  assign w_capture = (zc_mode_t'(in_mode) == ZC_CTZ) ? w_rev : in_data;

  // Window under test is the top 'half' bits of the shift register.
  assign w_half       = {{(CW-1){1'b0}}, 1'b1} << r_step;
  assign w_mask       = ~({WIDTH{1'b1}} >> w_half);
  assign w_upper_zero = ((r_sr & w_mask) == '0);

  assign in_ready  = (r_state == ZC_IDLE) || ((r_state == ZC_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready && !flush;

  assign out_valid = (r_state == ZC_DONE);
  assign out_count = r_count;
  assign out_zero  = r_zero;
  assign out_tag   = r_tag;

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_count_nxt = r_count;
    w_step_nxt  = r_step;
    w_tag_nxt   = r_tag;
    w_zero_nxt  = r_zero;

    if (flush) begin
      w_state_nxt = ZC_IDLE;
    end else if (w_accept) begin
      w_sr_nxt   = w_capture;
      w_tag_nxt  = in_tag;
      w_step_nxt = SW'(LOG2W - 1);
      if (in_data == '0) begin
        w_count_nxt = CW'(WIDTH);
        w_zero_nxt  = 1'b1;
        w_state_nxt = ZC_DONE;
      end else begin
        w_count_nxt = '0;
        w_zero_nxt  = 1'b0;
        w_state_nxt = ZC_SEARCH;
      end
    end else begin
      case (r_state)
        ZC_SEARCH: begin
          if (w_upper_zero) begin
            w_sr_nxt    = r_sr << w_half;
            w_count_nxt = r_count + w_half;
          end
          if (r_step == '0) w_state_nxt = ZC_DONE;
          else              w_step_nxt  = r_step - 1'b1;
        end
        ZC_DONE: begin
          if (out_ready) w_state_nxt = ZC_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ZC_IDLE;
      r_sr    <= '0;
      r_count <= '0;
      r_step  <= '0;
      r_tag   <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_count <= w_count_nxt;
      r_step  <= w_step_nxt;
      r_tag   <= w_tag_nxt;
      r_zero  <= w_zero_nxt;
    end
  end

endmodule
